cmos_nvram_arbiter: RTL and testbench
=====================================

Name: cmos_nvram_arbiter

Overview:
- Owns the Williams-2 battery-backed CMOS RAM (DEPTH x 4 bit, single-port storage).
- Arbitrates that RAM between the game CPU and the HPS save/load channel, so high scores and settings can be downloaded from or uploaded to the SD card.
- Sequences each HPS transfer: requests a CPU hold, waits for acknowledge or timeout, streams bytes, then releases the CPU.
- Sits beside williams2 on clock_12; the top level qualifies the HPS strobes by ioctl_index.

Parameters:
ADDR_W, 10, CMOS address width.
DEPTH, 1024, number of nibble locations (at most 2^ADDR_W).
HOLD_TIMEOUT, 4096, clock_12 cycles to wait for cpu_hold_ack before forcing the transfer.

Ports:
clock_12  in  1  system clock (12 MHz); single clock domain.
reset  in  1  asynchronous, active-high reset.
cpu_addr  in  ADDR_W  CPU CMOS address.
cpu_din  in  4  CPU write data.
cpu_cs  in  1  CPU CMOS select.
cpu_we  in  1  CPU write strobe, qualified by cpu_cs.
cpu_dout  out  4  CPU read data, registered.
cpu_hold  out  1  pause request to the CPU.
cpu_hold_ack  in  1  CPU parked at a safe point.
hps_download  in  1  HPS-to-CMOS load active, level.
hps_upload  in  1  CMOS-to-HPS dump active, level.
hps_wr  in  1  byte write strobe, one cycle.
hps_rd  in  1  byte read strobe, one cycle.
hps_addr  in  16  HPS byte address.
hps_din  in  8  HPS write byte.
hps_dout  out  8  HPS read byte.
hps_wait  out  1  HPS must stall strobes while high.
dirty  out  1  CPU has written the RAM since the last completed dump.
timeout  out  1  last hold was forced without acknowledge (sticky until next hold request).

Behaviour:
Reset values:
- cpu_dout=0, hps_dout=0, cpu_hold=0, hps_wait=0, dirty=0, timeout=0, state=IDLE, timer=0.
- RAM contents are not cleared by reset.

FSM states: IDLE, HOLD_REQ, XFER_LOAD, XFER_DUMP, RELEASE.

IDLE:
- CPU owns the RAM.
- cpu_cs & cpu_we writes cpu_din at cpu_addr on the clock edge and sets dirty.
- cpu_cs read: cpu_dout = RAM[cpu_addr] one cycle later (latency 1). cpu_dout holds its value when cpu_cs=0.
- hps_download or hps_upload high moves to HOLD_REQ next cycle. The same edge sets cpu_hold=1 and hps_wait=1, clears timeout and clears timer.

HOLD_REQ:
- timer increments every cycle.
- cpu_hold_ack=1 moves to XFER_LOAD if hps_download=1, else XFER_DUMP.
- timer reaching HOLD_TIMEOUT-1 takes the same transition and sets timeout=1.
- hps_wait drops on the transition edge.
- Both request lines falling before the transfer starts moves to RELEASE.

XFER_LOAD:
- hps_wr writes hps_din[3:0] at hps_addr[ADDR_W-1:0]; hps_din[7:4] is discarded.
- Writes with hps_addr >= DEPTH are ignored.
- hps_rd is ignored.
- hps_download low moves to RELEASE.

XFER_DUMP:
- hps_rd gives hps_dout = {4'h0, RAM[hps_addr]} one cycle later.
- hps_addr >= DEPTH returns 8'h00.
- hps_wr is ignored.
- hps_upload low moves to RELEASE and clears dirty, unless a CPU write occurred (impossible while held).

RELEASE:
- One cycle: cpu_hold=0, hps_wait=0, then IDLE.

While cpu_hold=1:
- CPU writes are dropped.
- cpu_dout keeps its last value.

Simultaneous hps_download and hps_upload: download wins. Upload is ignored until both are low and the FSM has returned to IDLE.

A new request arriving in the RELEASE cycle is taken from IDLE on the following cycle, with no overlap.

HPS strobes arriving while hps_wait=1 are dropped. The HPS side is required to honour hps_wait.

Asynchronous reset mid-transfer:
- FSM returns to IDLE and cpu_hold drops immediately.
- A partially loaded RAM retains the bytes already written.

Test Plan:
- CPU write 4'hA at 0x012, then read 0x012 -> cpu_dout=4'hA the cycle after the read; dirty=1.
- hps_download rises, cpu_hold_ack after 10 cycles -> hps_wait high 11 cycles; writing 8'h5C at 0x012 stores nibble 4'hC. After release, a CPU read of 0x012 returns 4'hC and cpu_hold=0.
- hps_upload with cpu_hold_ack tied low -> transfer starts after exactly HOLD_TIMEOUT cycles with timeout=1. hps_rd at 0x012 gives hps_dout=8'h0C; dirty=0 after upload falls.
- During XFER_LOAD, a CPU write of 4'h3 at 0x020 is dropped (RAM unchanged). An HPS write at address 0x0400 (>= DEPTH) is ignored and does not alias to 0x000.
- hps_download and hps_upload asserted in the same cycle -> XFER_LOAD is entered and hps_rd produces no hps_dout change.
- reset pulsed in XFER_LOAD after 3 of 8 writes -> cpu_hold=0 immediately and the FSM is in IDLE. The 3 written nibbles are readable by the CPU; the remaining locations are unchanged.

Source files
------------

// File: rtl/cmos_nvram_arbiter.sv
// Williams-2 CMOS nibble RAM shared between the game CPU and the HPS.
// HPS transfers hold the CPU, stream bytes, then hand the RAM back.
module cmos_nvram_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DEPTH        = 1024,
  parameter int HOLD_TIMEOUT = 4096
) (
  input  logic              clock_12,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [3:0]        cpu_din,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  output logic [3:0]        cpu_dout,
  output logic              cpu_hold,
  input  logic              cpu_hold_ack,
  input  logic              hps_download,
  input  logic              hps_upload,
  input  logic              hps_wr,
  input  logic              hps_rd,
  input  logic [15:0]       hps_addr,
  input  logic [7:0]        hps_din,
  output logic [7:0]        hps_dout,
  output logic              hps_wait,
  output logic              dirty,
  output logic              timeout
);

  localparam int TW = $clog2(HOLD_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE,
    HOLD_REQ,
    XFER_LOAD,
    XFER_DUMP,
    RELEASE
  } state_t;

  state_t state, state_nxt;

  logic [3:0]        mem [DEPTH];
  logic [TW-1:0]     timer;
  logic              up_lock;
  logic              up_req;
  logic              any_req;
  logic              tmo_hit;
  logic              start_hold;
  logic              force_xfer;
  logic              dump_done;
  logic              cpu_ok;
  logic              hps_ok;
  logic              cpu_wr;
  logic              hps_wr_ok;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_wdata;
  logic [3:0]        ram_rdata;
  logic              hold_nxt;
  logic              unused_hi;

  assign unused_hi = ^hps_din[7:4];

  // Upload is locked out after a simultaneous request until both lines drop
  assign up_req  = hps_upload & ~up_lock;
  assign any_req = hps_download | up_req;
  assign tmo_hit = (timer == TW'(HOLD_TIMEOUT - 1));

  assign cpu_ok = {{(32-ADDR_W){1'b0}}, cpu_addr} < 32'(DEPTH);
  assign hps_ok = {16'h0, hps_addr} < 32'(DEPTH);

  always_comb begin
    state_nxt  = state;
    start_hold = 1'b0;
    force_xfer = 1'b0;
    dump_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt  = HOLD_REQ;
          start_hold = 1'b1;
        end
      end
      HOLD_REQ: begin
        if (!any_req) begin
          state_nxt = RELEASE;
        end else if (cpu_hold_ack || tmo_hit) begin
          state_nxt  = hps_download ? XFER_LOAD
                                    : XFER_DUMP;
          force_xfer = ~cpu_hold_ack;
        end
      end
      XFER_LOAD: begin
        if (!hps_download) state_nxt = RELEASE;
      end
      XFER_DUMP: begin
        if (!hps_upload) begin
          state_nxt = RELEASE;
          dump_done = 1'b1;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign hold_nxt = (state_nxt == HOLD_REQ)  ||
                    (state_nxt == XFER_LOAD) ||
                    (state_nxt == XFER_DUMP);

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  assign cpu_wr    = (state == IDLE) & cpu_cs & cpu_we & cpu_ok;
  assign hps_wr_ok = (state == XFER_LOAD) & hps_wr & hps_ok;

  // One address port: HPS owns it during transfers, CPU otherwise
  assign ram_we    = cpu_wr | hps_wr_ok;
  assign ram_addr  = ((state == XFER_LOAD) || (state == XFER_DUMP))
                   ? hps_addr[ADDR_W-1:0] : cpu_addr;
  assign ram_wdata = (state == XFER_LOAD) ? hps_din[3:0] : cpu_din;
  assign ram_rdata = mem[ram_addr];

  always_ff @(posedge clock_12) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      cpu_hold <= 1'b0;
      hps_wait <= 1'b0;
      timer    <= '0;
      timeout  <= 1'b0;
      dirty    <= 1'b0;
      up_lock  <= 1'b0;
      cpu_dout <= 4'h0;
      hps_dout <= 8'h00;
    end else begin
      cpu_hold <= hold_nxt;
      hps_wait <= (state_nxt == HOLD_REQ);

      if (start_hold)
        timer <= '0;
      else if (state == HOLD_REQ)
        timer <= timer + 1'b1;

      if (start_hold)
        timeout <= 1'b0;
      else if (force_xfer)
        timeout <= 1'b1;

      if (cpu_wr)
        dirty <= 1'b1;
      else if (dump_done)
        dirty <= 1'b0;

      if (!hps_download && !hps_upload)
        up_lock <= 1'b0;
      else if (start_hold && hps_download && hps_upload)
        up_lock <= 1'b1;

      if ((state == IDLE) && cpu_cs)
        cpu_dout <= cpu_ok ? ram_rdata : 4'h0;

      if ((state == XFER_DUMP) && hps_rd)
        hps_dout <= hps_ok ? {4'h0, ram_rdata} : 8'h00;
    end
  end

endmodule

// File: tb/tb_cmos_nvram_arbiter.sv
// Directed bench for cmos_nvram_arbiter with a queued scoreboard.
// Expected values are queued at stimulus time, popped when observed.
module tb_cmos_nvram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  cpu_addr = '0;
  logic [3:0]  cpu_din = '0;
  logic        cpu_cs = 1'b0;
  logic        cpu_we = 1'b0;
  logic [3:0]  cpu_dout;
  logic        cpu_hold;
  logic        cpu_hold_ack = 1'b0;
  logic        hps_download = 1'b0;
  logic        hps_upload = 1'b0;
  logic        hps_wr = 1'b0;
  logic        hps_rd = 1'b0;
  logic [15:0] hps_addr = '0;
  logic [7:0]  hps_din = '0;
  logic [7:0]  hps_dout;
  logic        hps_wait;
  logic        dirty;
  logic        timeout;

  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   w;

  always #5 clk = ~clk;

  cmos_nvram_arbiter dut (
    .clock_12     (clk),
    .reset        (rst),
    .cpu_addr     (cpu_addr),
    .cpu_din      (cpu_din),
    .cpu_cs       (cpu_cs),
    .cpu_we       (cpu_we),
    .cpu_dout     (cpu_dout),
    .cpu_hold     (cpu_hold),
    .cpu_hold_ack (cpu_hold_ack),
    .hps_download (hps_download),
    .hps_upload   (hps_upload),
    .hps_wr       (hps_wr),
    .hps_rd       (hps_rd),
    .hps_addr     (hps_addr),
    .hps_din      (hps_din),
    .hps_dout     (hps_dout),
    .hps_wait     (hps_wait),
    .dirty        (dirty),
    .timeout      (timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [15:0] obs);
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic cpu_write(input logic [9:0] a, input logic [3:0] d);
    cpu_addr = a;
    cpu_din  = d;
    cpu_cs   = 1'b1;
    cpu_we   = 1'b1;
    tick();
    cpu_cs   = 1'b0;
    cpu_we   = 1'b0;
  endtask

  task automatic cpu_rd_chk(input string tag, input logic [9:0] a,
                            input logic [3:0] d);
    expect_v(tag, {12'h0, d});
    cpu_addr = a;
    cpu_cs   = 1'b1;
    tick();
    cpu_cs   = 1'b0;
    chk({12'h0, cpu_dout});
  endtask

  task automatic hps_write(input logic [15:0] a, input logic [7:0] d);
    hps_addr = a;
    hps_din  = d;
    hps_wr   = 1'b1;
    tick();
    hps_wr   = 1'b0;
  endtask

  task automatic hps_rd_chk(input string tag, input logic [15:0] a,
                            input logic [7:0] d);
    expect_v(tag, {8'h0, d});
    hps_addr = a;
    hps_rd   = 1'b1;
    tick();
    hps_rd   = 1'b0;
    chk({8'h0, hps_dout});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b1;
    #4;
    expect_v("rst_cpu_dout", 16'h0); chk({12'h0, cpu_dout});
    expect_v("rst_hps_dout", 16'h0); chk({8'h0, hps_dout});
    expect_v("rst_cpu_hold", 16'h0); chk({15'h0, cpu_hold});
    expect_v("rst_hps_wait", 16'h0); chk({15'h0, hps_wait});
    expect_v("rst_dirty", 16'h0);    chk({15'h0, dirty});
    expect_v("rst_timeout", 16'h0);  chk({15'h0, timeout});
    tick();
    rst = 1'b0;
    tick();

    // CPU write/read, known background for later checks
    cpu_write(10'h012, 4'hA);
    cpu_rd_chk("cpu_rd_012", 10'h012, 4'hA);
    expect_v("cpu_dout_hold", 16'hA);
    tick();
    chk({12'h0, cpu_dout});
    expect_v("dirty_set", 16'h1); chk({15'h0, dirty});
    cpu_write(10'h020, 4'h9);
    cpu_write(10'h000, 4'h1);
    for (int i = 0; i < 8; i++)
      cpu_write(10'h100 + 10'(i), 4'(8 + i));

    // Download, ack raised in the 11th hold cycle
    hps_download = 1'b1;
    tick();
    w = 0;
    for (int i = 0; i < 100; i++) begin
      if (!hps_wait) break;
      w++;
      if (w == 11) cpu_hold_ack = 1'b1;
      tick();
    end
    expect_v("dl_wait_cycles", 16'd11); chk(16'(w));
    expect_v("dl_cpu_hold", 16'h1); chk({15'h0, cpu_hold});
    expect_v("dl_timeout", 16'h0);  chk({15'h0, timeout});
    hps_write(16'h0012, 8'h5C);
    cpu_write(10'h020, 4'h3);
    hps_write(16'h0400, 8'hF7);
    hps_rd_chk("load_rd_ignored", 16'h0012, 8'h00);
    hps_download = 1'b0;
    tick();
    expect_v("rel_cpu_hold", 16'h0); chk({15'h0, cpu_hold});
    tick();
    cpu_hold_ack = 1'b0;
    cpu_rd_chk("post_dl_012", 10'h012, 4'hC);
    cpu_rd_chk("cpu_wr_dropped", 10'h020, 4'h9);
    cpu_rd_chk("no_alias_000", 10'h000, 4'h1);

    // Upload with no acknowledge: forced after HOLD_TIMEOUT
    hps_upload = 1'b1;
    tick();
    w = 0;
    for (int i = 0; i < 5000; i++) begin
      if (!hps_wait) break;
      w++;
      tick();
    end
    expect_v("ul_wait_cycles", 16'd4096); chk(16'(w));
    expect_v("ul_timeout", 16'h1); chk({15'h0, timeout});
    hps_rd_chk("ul_rd_012", 16'h0012, 8'h0C);
    hps_rd_chk("ul_rd_oob", 16'h0400, 8'h00);
    hps_write(16'h0012, 8'h33);
    hps_rd_chk("ul_wr_ignored", 16'h0012, 8'h0C);
    expect_v("ul_dirty_before", 16'h1); chk({15'h0, dirty});
    hps_upload = 1'b0;
    tick();
    expect_v("ul_dirty_clr", 16'h0); chk({15'h0, dirty});
    expect_v("ul_timeout_sticky", 16'h1); chk({15'h0, timeout});
    tick();

    // Simultaneous requests: download wins, upload locked out
    hps_download = 1'b1;
    hps_upload   = 1'b1;
    tick();
    expect_v("both_timeout_clr", 16'h0); chk({15'h0, timeout});
    cpu_hold_ack = 1'b1;
    tick();
    expect_v("both_wait_low", 16'h0); chk({15'h0, hps_wait});
    hps_rd_chk("both_no_dump", 16'h0000, 8'h0C);
    hps_download = 1'b0;
    repeat (5) tick();
    expect_v("both_upload_locked", 16'h0); chk({15'h0, cpu_hold});
    hps_upload = 1'b0;
    cpu_hold_ack = 1'b0;
    tick();

    // Reset in the middle of a load
    hps_download = 1'b1;
    cpu_hold_ack = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++)
      hps_write(16'h0100 + 16'(i), 8'hA0 | 8'(i + 1));
    rst = 1'b1;
    #1;
    expect_v("mid_rst_cpu_hold", 16'h0); chk({15'h0, cpu_hold});
    expect_v("mid_rst_hps_wait", 16'h0); chk({15'h0, hps_wait});
    @(posedge clk);
    #1;
    hps_download = 1'b0;
    cpu_hold_ack = 1'b0;
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++)
      cpu_rd_chk("mid_rst_ram", 10'h100 + 10'(i),
                 (i < 3) ? 4'(i + 1) : 4'(8 + i));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
